// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the program sequencer and its return-address stack.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF        = 16;
  localparam int unsigned INSTR_BYTES_DEF = 2;
  localparam int unsigned BR_IMM_W_DEF    = 6;
  localparam int unsigned JMP_IMM_W_DEF   = 12;
  localparam int unsigned RAS_DEPTH_DEF   = 4;
  localparam logic [15:0] RESET_PC_DEF    = 16'h0000;
  localparam logic [15:0] IRQ_VECTOR_DEF  = 16'h0010;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_RET,
    SEL_IRQ,
    SEL_ERET
  } npc_sel_e;

  // Sign-extend the low w bits of val to 32 bits; callers truncate to PC width.
  function automatic logic [31:0] sext32(input logic [31:0] val, input int unsigned w);
    logic [31:0] shifted;
    shifted = val << (32 - w);
    return $signed(shifted) >>> (32 - w);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// a pop when empty leaves the stack untouched. Overflow/underflow are
// combinational indications for the current request.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk_pi,
  input  logic            reset_pi,
  input  logic            push_pi,
  input  logic            pop_pi,
  input  logic [PC_W-1:0] push_data_pi,
  output logic [PC_W-1:0] top_po,
  output logic            full_po,
  output logic            empty_po,
  output logic            overflow_po,
  output logic            underflow_po
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full_po      = (count_q == CNT_W'(RAS_DEPTH));
  assign empty_po     = (count_q == '0);
  assign top_po       = mem_q[ptr_q - 1'b1];
  assign overflow_po  = push_pi & full_po;
  assign underflow_po = pop_pi & empty_po;

  // Pointer and occupancy; the pointer always names the next slot to write.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push_pi) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full_po) count_q <= count_q + 1'b1;
    end else if (pop_pi && !empty_po) begin
      ptr_q   <= ptr_q - 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  // Entry storage, no reset needed since occupancy gates every read.
  always_ff @(posedge clk_pi) begin
    if (!reset_pi && push_pi) mem_q[ptr_q] <= push_data_pi;
  end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-stage program counter with stall, branch/jump, call/return through a
// hardware return-address stack, and an optional interrupt vector enabled by
// the PC_IRQ_EN macro (adds irq_pi, eret_pi and irq_ack_po).
module program_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W        = PC_W_DEF,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int unsigned     BR_IMM_W    = BR_IMM_W_DEF,
  parameter int unsigned     JMP_IMM_W   = JMP_IMM_W_DEF,
  parameter int unsigned     RAS_DEPTH   = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEF),
  parameter logic [PC_W-1:0] IRQ_VECTOR  = PC_W'(IRQ_VECTOR_DEF)
) (
  input  logic                 clk_pi,
  input  logic                 reset_pi,
  input  logic                 clk_en_pi,
  input  logic                 stall_pi,
  input  logic                 branch_taken_pi,
  input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
  input  logic                 jump_taken_pi,
  input  logic                 call_pi,
  input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
  input  logic                 ret_pi,
  output logic [PC_W-1:0]      pc_po,
  output logic                 ras_empty_po,
  output logic                 ras_full_po,
  output logic                 ras_err_po
`ifdef PC_IRQ_EN
  ,
  input  logic                 irq_pi,
  input  logic                 eret_pi,
  output logic                 irq_ack_po
`endif
);

  // Power-up value before the first reset is all-ones.
  logic [PC_W-1:0] pc_q = '1;
  logic            err_q;
  logic            rst_act;
  logic            advance;
  npc_sel_e        sel;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] jmp_off;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] eret_target;
  logic            irq_take;
  logic            eret_take;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_ovf;
  logic            ras_unf;

  assign rst_act = clk_en_pi & reset_pi;
  assign advance = clk_en_pi & ~stall_pi & ~reset_pi;
  assign npc     = pc_q + PC_W'(INSTR_BYTES);
  assign br_off  = PC_W'(sext32(32'(branch_immediate_pi), BR_IMM_W));
  assign jmp_off = PC_W'(sext32(32'(jump_immediate_pi), JMP_IMM_W));

`ifdef PC_IRQ_EN
  logic            irq_mask_q;
  logic [PC_W-1:0] epc_q;
  logic            ack_q;

  assign irq_take    = irq_pi & ~irq_mask_q;
  assign eret_take   = eret_pi & irq_mask_q;
  assign eret_target = epc_q;
  assign irq_ack_po  = ack_q;

  // Interrupt mask, saved return PC and one-cycle acknowledge pulse.
  always_ff @(posedge clk_pi) begin
    if (rst_act) begin
      irq_mask_q <= 1'b0;
      epc_q      <= '0;
      ack_q      <= 1'b0;
    end else if (clk_en_pi) begin
      ack_q <= advance & (sel == SEL_IRQ);
      if (advance && sel == SEL_IRQ) begin
        irq_mask_q <= 1'b1;
        epc_q      <= npc;
      end else if (advance && sel == SEL_ERET) begin
        irq_mask_q <= 1'b0;
      end
    end
  end
`else
  assign irq_take    = 1'b0;
  assign eret_take   = 1'b0;
  assign eret_target = '0;
`endif

  // Priority encoder: irq > eret > ret > branch > jump/call > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (irq_take)                      sel = SEL_IRQ;
    else if (eret_take)                sel = SEL_ERET;
    else if (ret_pi)                   sel = SEL_RET;
    else if (branch_taken_pi)          sel = SEL_BR;
    else if (jump_taken_pi || call_pi) sel = SEL_JMP;
  end

  // Next-PC mux; a return from an empty stack falls through to sequential.
  always_comb begin
    pc_next = npc;
    case (sel)
      SEL_BR:   pc_next = npc + br_off;
      SEL_JMP:  pc_next = npc + jmp_off;
      SEL_RET:  pc_next = ras_empty_po ? npc : ras_top;
      SEL_IRQ:  pc_next = IRQ_VECTOR;
      SEL_ERET: pc_next = eret_target;
      default:  pc_next = npc;
    endcase
  end

  assign ras_push = advance & (sel == SEL_JMP) & call_pi;
  assign ras_pop  = advance & (sel == SEL_RET);

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_pi       (clk_pi),
    .reset_pi     (rst_act),
    .push_pi      (ras_push),
    .pop_pi       (ras_pop),
    .push_data_pi (npc),
    .top_po       (ras_top),
    .full_po      (ras_full_po),
    .empty_po     (ras_empty_po),
    .overflow_po  (ras_ovf),
    .underflow_po (ras_unf)
  );

  // PC register and sticky stack-error flag.
  always_ff @(posedge clk_pi) begin
    if (rst_act) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else if (advance) begin
      pc_q <= pc_next;
      if (ras_ovf || ras_unf) err_q <= 1'b1;
    end
  end

  assign pc_po      = pc_q;
  assign ras_err_po = err_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic        clk_en_pi;
  logic        stall_pi;
  logic        branch_taken_pi;
  logic [5:0]  branch_immediate_pi;
  logic        jump_taken_pi;
  logic        call_pi;
  logic [11:0] jump_immediate_pi;
  logic        ret_pi;
  logic [15:0] pc_po;
  logic        ras_empty_po;
  logic        ras_full_po;
  logic        ras_err_po;
  logic        irq_pi;
  logic        eret_pi;
  logic        irq_ack_po;

  int tests = 0;
  int fails = 0;

  always #5 clk_pi = ~clk_pi;

  program_sequencer dut (
    .clk_pi              (clk_pi),
    .reset_pi            (reset_pi),
    .clk_en_pi           (clk_en_pi),
    .stall_pi            (stall_pi),
    .branch_taken_pi     (branch_taken_pi),
    .branch_immediate_pi (branch_immediate_pi),
    .jump_taken_pi       (jump_taken_pi),
    .call_pi             (call_pi),
    .jump_immediate_pi   (jump_immediate_pi),
    .ret_pi              (ret_pi),
    .pc_po               (pc_po),
    .ras_empty_po        (ras_empty_po),
    .ras_full_po         (ras_full_po),
    .ras_err_po          (ras_err_po)
`ifdef PC_IRQ_EN
    ,
    .irq_pi              (irq_pi),
    .eret_pi             (eret_pi),
    .irq_ack_po          (irq_ack_po)
`endif
  );

`ifndef PC_IRQ_EN
  assign irq_ack_po = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset_pi            = 1'b0;
    clk_en_pi           = 1'b1;
    stall_pi            = 1'b0;
    branch_taken_pi     = 1'b0;
    branch_immediate_pi = '0;
    jump_taken_pi       = 1'b0;
    call_pi             = 1'b0;
    jump_immediate_pi   = '0;
    ret_pi              = 1'b0;
    irq_pi              = 1'b0;
    eret_pi             = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_pi);
    #1;
  endtask

  initial begin
    idle();
    reset_pi = 1'b1;
    #1;
    chk("init_pc", 32'(pc_po), 32'hFFFF);

    // 1. reset and free-running increment
    cyc();
    chk("rst_pc", 32'(pc_po), 32'h0000);
    chk("rst_empty", 32'(ras_empty_po), 32'd1);
    chk("rst_full", 32'(ras_full_po), 32'd0);
    chk("rst_err", 32'(ras_err_po), 32'd0);
    idle();
    cyc(); chk("seq1", 32'(pc_po), 32'h0002);
    cyc(); chk("seq2", 32'(pc_po), 32'h0004);
    cyc(); chk("seq3", 32'(pc_po), 32'h0006);

    // 2. branch backwards and branch-over-jump priority
    jump_taken_pi = 1'b1; jump_immediate_pi = 12'h008;
    cyc(); chk("jmp_to_10", 32'(pc_po), 32'h0010);
    idle(); branch_taken_pi = 1'b1; branch_immediate_pi = 6'h3E;
    cyc(); chk("br_neg", 32'(pc_po), 32'h0010);
    jump_taken_pi = 1'b1; jump_immediate_pi = 12'h100;
    cyc(); chk("br_over_jmp", 32'(pc_po), 32'h0010);

    // 3. call and return
    idle(); jump_taken_pi = 1'b1; jump_immediate_pi = 12'h00E;
    cyc(); chk("jmp_to_20", 32'(pc_po), 32'h0020);
    idle(); call_pi = 1'b1; jump_immediate_pi = 12'h040;
    cyc(); chk("call_pc", 32'(pc_po), 32'h0062);
    chk("call_nonempty", 32'(ras_empty_po), 32'd0);
    idle(); ret_pi = 1'b1;
    cyc(); chk("ret_pc", 32'(pc_po), 32'h0022);
    chk("ret_empty", 32'(ras_empty_po), 32'd1);

    // 4. overflow and underflow
    idle(); call_pi = 1'b1; jump_immediate_pi = 12'h000;
    cyc(); cyc(); cyc(); cyc();
    chk("call4_pc", 32'(pc_po), 32'h002A);
    chk("call4_full", 32'(ras_full_po), 32'd1);
    chk("call4_err", 32'(ras_err_po), 32'd0);
    cyc();
    chk("call5_pc", 32'(pc_po), 32'h002C);
    chk("call5_full", 32'(ras_full_po), 32'd1);
    chk("call5_err", 32'(ras_err_po), 32'd1);
    idle(); ret_pi = 1'b1;
    cyc(); chk("ret1", 32'(pc_po), 32'h002C);
    chk("ret1_full", 32'(ras_full_po), 32'd0);
    cyc(); chk("ret2", 32'(pc_po), 32'h002A);
    cyc(); chk("ret3", 32'(pc_po), 32'h0028);
    cyc(); chk("ret4", 32'(pc_po), 32'h0026);
    chk("ret4_empty", 32'(ras_empty_po), 32'd1);
    cyc(); chk("ret5_npc", 32'(pc_po), 32'h0028);
    chk("ret5_empty", 32'(ras_empty_po), 32'd1);
    chk("ret5_err", 32'(ras_err_po), 32'd1);

    // losing call does not push
    idle(); branch_taken_pi = 1'b1; branch_immediate_pi = 6'h04; call_pi = 1'b1;
    cyc(); chk("br_over_call", 32'(pc_po), 32'h002E);
    chk("lost_call_empty", 32'(ras_empty_po), 32'd1);

    // 5. wrap, stall, clock enable, reset during stall
    idle(); jump_taken_pi = 1'b1; jump_immediate_pi = 12'hFCE;
    cyc(); chk("jmp_to_fffe", 32'(pc_po), 32'hFFFE);
    idle();
    cyc(); chk("wrap", 32'(pc_po), 32'h0000);
    cyc(); chk("post_wrap", 32'(pc_po), 32'h0002);
    stall_pi = 1'b1; branch_taken_pi = 1'b1; branch_immediate_pi = 6'h10;
    cyc(); cyc(); cyc();
    chk("stall_hold", 32'(pc_po), 32'h0002);
    stall_pi = 1'b0; clk_en_pi = 1'b0; reset_pi = 1'b1;
    cyc(); cyc(); cyc();
    chk("clken_hold", 32'(pc_po), 32'h0002);
    chk("clken_err_hold", 32'(ras_err_po), 32'd1);
    clk_en_pi = 1'b1; stall_pi = 1'b1;
    cyc();
    chk("rst_in_stall_pc", 32'(pc_po), 32'h0000);
    chk("rst_in_stall_err", 32'(ras_err_po), 32'd0);

`ifdef PC_IRQ_EN
    // 6. interrupt entry, masking and return
    idle(); jump_taken_pi = 1'b1; jump_immediate_pi = 12'h02E;
    cyc(); chk("jmp_to_30", 32'(pc_po), 32'h0030);
    idle(); irq_pi = 1'b1; branch_taken_pi = 1'b1;
    cyc(); chk("irq_pc", 32'(pc_po), 32'h0010);
    chk("irq_ack", 32'(irq_ack_po), 32'd1);
    idle(); irq_pi = 1'b1;
    cyc(); chk("irq_masked", 32'(pc_po), 32'h0012);
    chk("ack_pulse", 32'(irq_ack_po), 32'd0);
    idle(); eret_pi = 1'b1;
    cyc(); chk("eret_pc", 32'(pc_po), 32'h0032);
    cyc(); chk("eret_unmasked_seq", 32'(pc_po), 32'h0034);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
